label_merge_ctrl: RTL and testbench
===================================

Name: label_merge_ctrl

Overview:
- Sequencer and arbiter in front of the label_merger union table.
- Shares the table's single merge and resolve ports between the connected-component labeler (merges) and the bbox tracker (resolves).
- At frame end, flattens the table in one ascending sweep so every entry points directly at its root.
- At frame start, re-initialises the table to identity before labeling begins.

Parameters:
- LABEL_WIDTH, 6, label bit width.
- NUM_LABELS, 1<<LABEL_WIDTH, table depth swept by FLATTEN and CLEAR.
- STARVE_LIMIT, 4, maximum consecutive merge grants while a resolve is waiting.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- frame_start  in  1  pulse: a new frame begins.
- frame_end  in  1  pulse: labeling of the frame is complete.
- mrg_valid  in  1  merge request from the labeler.
- mrg_ready  out  1  merge request accepted this cycle.
- mrg_a  in  LABEL_WIDTH  first label to merge.
- mrg_b  in  LABEL_WIDTH  second label to merge.
- rsv_valid  in  1  resolve request from the bbox tracker.
- rsv_ready  out  1  resolve request accepted this cycle.
- rsv_label  in  LABEL_WIDTH  label to resolve.
- rsp_valid  out  1  resolve response valid (no backpressure).
- rsp_label  out  LABEL_WIDTH  resolved root label.
- tbl_merge_valid  out  1  to label_merger merge_valid.
- tbl_merge_a  out  LABEL_WIDTH  to label_merger merge_a.
- tbl_merge_b  out  LABEL_WIDTH  to label_merger merge_b.
- tbl_resolve_valid  out  1  to label_merger resolve_valid.
- tbl_resolve_label  out  LABEL_WIDTH  to label_merger resolve_label.
- tbl_resolved_label  in  LABEL_WIDTH  from label_merger resolved_label (combinational).
- busy  out  1  high while in CLEAR or FLATTEN.
- flatten_done  out  1  one-cycle pulse when the flatten sweep completes.
- seq_err  out  1  sticky frame-sequencing error flag.

Behaviour:
- Reset values: state=IDLE; idx=0; starve_cnt=0; all outputs 0.
- States: IDLE, CLEAR, RUN, FLATTEN, FROZEN.
- IDLE:
  - Both readys low.
  - frame_start -> CLEAR.
- CLEAR:
  - busy=1; readys low.
  - Each cycle drives tbl_merge_valid=1, tbl_merge_a=tbl_merge_b=idx, then idx++.
  - After idx=NUM_LABELS-1: idx<=0, go to RUN. Takes exactly NUM_LABELS cycles.
- RUN arbitration (at most one table operation per cycle):
  - Merge has priority over resolve.
  - If rsv_valid is pending and starve_cnt==STARVE_LIMIT, the resolve wins.
  - starve_cnt increments on each merge grant made while rsv_valid=1; clears on a resolve grant or when rsv_valid=0.
  - mrg_ready and rsv_ready are combinational grant signals; a transfer occurs when valid&&ready.
- Merge canonicalisation:
  - Drive tbl_merge_a=min(mrg_a,mrg_b) and tbl_merge_b=max(mrg_a,mrg_b), so a parent is always lower than its child.
  - If mrg_a==mrg_b, the request is accepted but tbl_merge_valid stays 0.
- Resolve:
  - On the grant cycle T, drive tbl_resolve_valid=1 and tbl_resolve_label=rsv_label.
  - Register tbl_resolved_label; rsp_valid=1 and rsp_label at T+1. Fixed latency 1.
- frame_end in RUN:
  - Any operation granted in the same cycle still completes.
  - Next state FLATTEN, idx=0.
- FLATTEN:
  - busy=1; readys low.
  - Each cycle: tbl_resolve_valid=1, tbl_resolve_label=idx, tbl_merge_valid=1, tbl_merge_b=idx, tbl_merge_a=tbl_resolved_label.
  - The ascending order plus min-parent rule guarantees one pass fully flattens the table.
  - After the last idx: pulse flatten_done, go to FROZEN.
- FROZEN:
  - Resolves only: rsv_ready=rsv_valid; mrg_ready=0.
  - frame_start -> CLEAR.
- Sequencing errors (set seq_err sticky until rst; the state is unaffected):
  - frame_start in RUN, CLEAR or FLATTEN.
  - frame_end in any state other than RUN.
  - frame_start and frame_end in the same cycle in RUN: frame_end is taken and seq_err is set.
- Asynchronous rst mid-sweep: returns immediately to IDLE with idx=0. rsp_valid is not produced for an in-flight resolve.

Test Plan:
- Reset, then frame_start -> busy=1 for exactly 64 cycles with tbl_merge_a=tbl_merge_b=0..63, then RUN with mrg_ready=1 on the first valid.
- In RUN, merge (9,3), then resolve 9 -> tbl_merge_a=3, tbl_merge_b=9; rsp_valid one cycle after the resolve grant with rsp_label=3.
- mrg_valid held high for 10 cycles with rsv_valid held high -> resolve granted after exactly 4 merges; starve_cnt resets; merges resume.
- Merges (2,5), (5,7), (7,12), then frame_end -> FLATTEN writes entries 5, 7 and 12 with parent 2; flatten_done pulses after 64 cycles; in FROZEN, resolving 12 returns 2.
- Merge (4,4) -> mrg_ready=1, tbl_merge_valid=0, table unchanged.
- frame_start during FLATTEN -> seq_err=1, sweep continues to completion; rst asserted mid-CLEAR -> IDLE next cycle, all outputs 0, seq_err cleared.

Source files
------------

// File: rtl/label_merge_ctrl.sv
// Sequencer/arbiter in front of the label_merger union table: clears the table
// at frame start, arbitrates merges vs resolves, and flattens it at frame end.
module label_merge_ctrl #(
   parameter int LABEL_WIDTH  = 6,
   parameter int NUM_LABELS   = 1 << LABEL_WIDTH,
   parameter int STARVE_LIMIT = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   frame_start,
   input  logic                   frame_end,
   input  logic                   mrg_valid,
   output logic                   mrg_ready,
   input  logic [LABEL_WIDTH-1:0] mrg_a,
   input  logic [LABEL_WIDTH-1:0] mrg_b,
   input  logic                   rsv_valid,
   output logic                   rsv_ready,
   input  logic [LABEL_WIDTH-1:0] rsv_label,
   output logic                   rsp_valid,
   output logic [LABEL_WIDTH-1:0] rsp_label,
   output logic                   tbl_merge_valid,
   output logic [LABEL_WIDTH-1:0] tbl_merge_a,
   output logic [LABEL_WIDTH-1:0] tbl_merge_b,
   output logic                   tbl_resolve_valid,
   output logic [LABEL_WIDTH-1:0] tbl_resolve_label,
   input  logic [LABEL_WIDTH-1:0] tbl_resolved_label,
   output logic                   busy,
   output logic                   flatten_done,
   output logic                   seq_err
);

   localparam int SW = $clog2(STARVE_LIMIT + 1);
   localparam logic [LABEL_WIDTH-1:0] LAST_IDX = LABEL_WIDTH'(NUM_LABELS - 1);
   localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CLEAR,
      S_RUN,
      S_FLATTEN,
      S_FROZEN
   } state_t;

   state_t                 r_state, w_state_nxt;
   logic [LABEL_WIDTH-1:0] r_idx, w_idx_nxt;
   logic [SW-1:0]          r_starve_cnt, w_starve_nxt;
   logic                   r_seq_err, w_seq_err_nxt;
   logic                   r_flatten_done, w_flatten_last;
   logic                   r_rsp_vld_p1;
   logic [LABEL_WIDTH-1:0] r_rsp_label_p1;
   logic                   w_rsv_win;
   logic [LABEL_WIDTH-1:0] w_mrg_lo, w_mrg_hi;

   // A waiting resolve wins when no merge competes or the merge streak hit the limit
   assign w_rsv_win = rsv_valid && (!mrg_valid || (r_starve_cnt == STARVE_MAX));
   assign w_mrg_lo  = (mrg_a < mrg_b) ? mrg_a : mrg_b;
   assign w_mrg_hi  = (mrg_a < mrg_b) ? mrg_b : mrg_a;

   always_comb begin
      w_state_nxt       = r_state;
      w_idx_nxt         = r_idx;
      w_starve_nxt      = '0;
      w_seq_err_nxt     = r_seq_err;
      w_flatten_last    = 1'b0;
      mrg_ready         = 1'b0;
      rsv_ready         = 1'b0;
      tbl_merge_valid   = 1'b0;
      tbl_merge_a       = '0;
      tbl_merge_b       = '0;
      tbl_resolve_valid = 1'b0;
      tbl_resolve_label = '0;
      busy              = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (frame_end) w_seq_err_nxt = 1'b1;
            if (frame_start) begin
               w_state_nxt = S_CLEAR;
               w_idx_nxt   = '0;
            end
         end
         S_CLEAR: begin
            busy            = 1'b1;
            tbl_merge_valid = 1'b1;
            tbl_merge_a     = r_idx;
            tbl_merge_b     = r_idx;
            w_idx_nxt       = r_idx + 1'b1;
            if (frame_start || frame_end) w_seq_err_nxt = 1'b1;
            if (r_idx == LAST_IDX) begin
               w_idx_nxt   = '0;
               w_state_nxt = S_RUN;
            end
         end
         S_RUN: begin
            mrg_ready = mrg_valid && !w_rsv_win;
            rsv_ready = w_rsv_win;
            if (mrg_ready) begin
               // Self-merges are acknowledged but never touch the table
               tbl_merge_valid = (mrg_a != mrg_b);
               tbl_merge_a     = w_mrg_lo;
               tbl_merge_b     = w_mrg_hi;
            end
            if (rsv_ready) begin
               tbl_resolve_valid = 1'b1;
               tbl_resolve_label = rsv_label;
            end
            if (rsv_valid && !rsv_ready && mrg_ready) w_starve_nxt = r_starve_cnt + SW'(1);
            if (frame_start) w_seq_err_nxt = 1'b1;
            if (frame_end) begin
               w_state_nxt  = S_FLATTEN;
               w_idx_nxt    = '0;
               w_starve_nxt = '0;
            end
         end
         S_FLATTEN: begin
            busy              = 1'b1;
            tbl_resolve_valid = 1'b1;
            tbl_resolve_label = r_idx;
            tbl_merge_valid   = 1'b1;
            tbl_merge_a       = tbl_resolved_label;
            tbl_merge_b       = r_idx;
            w_idx_nxt         = r_idx + 1'b1;
            if (frame_start || frame_end) w_seq_err_nxt = 1'b1;
            if (r_idx == LAST_IDX) begin
               w_idx_nxt      = '0;
               w_state_nxt    = S_FROZEN;
               w_flatten_last = 1'b1;
            end
         end
         S_FROZEN: begin
            rsv_ready = rsv_valid;
            if (rsv_ready) begin
               tbl_resolve_valid = 1'b1;
               tbl_resolve_label = rsv_label;
            end
            if (frame_end) w_seq_err_nxt = 1'b1;
            if (frame_start) begin
               w_state_nxt = S_CLEAR;
               w_idx_nxt   = '0;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state        <= S_IDLE;
         r_idx          <= '0;
         r_starve_cnt   <= '0;
         r_seq_err      <= 1'b0;
         r_flatten_done <= 1'b0;
         r_rsp_vld_p1   <= 1'b0;
         r_rsp_label_p1 <= '0;
      end else begin
         r_state        <= w_state_nxt;
         r_idx          <= w_idx_nxt;
         r_starve_cnt   <= w_starve_nxt;
         r_seq_err      <= w_seq_err_nxt;
         r_flatten_done <= w_flatten_last;
         // p1: resolve response, one cycle after the grant
         r_rsp_vld_p1   <= rsv_valid && rsv_ready;
         if (rsv_valid && rsv_ready) r_rsp_label_p1 <= tbl_resolved_label;
      end
   end

   assign rsp_valid    = r_rsp_vld_p1;
   assign rsp_label    = r_rsp_label_p1;
   assign flatten_done = r_flatten_done;
   assign seq_err      = r_seq_err;

endmodule

// File: tb/tb_label_merge_ctrl.sv
// Directed bench for label_merge_ctrl with a behavioural union-table model.
module tb_label_merge_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       frame_start = 1'b0, frame_end = 1'b0;
   logic       mrg_valid = 1'b0, rsv_valid = 1'b0;
   logic [5:0] mrg_a = '0, mrg_b = '0, rsv_label = '0;
   logic       mrg_ready, rsv_ready, rsp_valid;
   logic [5:0] rsp_label;
   logic       tbl_merge_valid, tbl_resolve_valid;
   logic [5:0] tbl_merge_a, tbl_merge_b, tbl_resolve_label, tbl_resolved_label;
   logic       busy, flatten_done, seq_err;

   int checks = 0;
   int errors = 0;

   logic [5:0] tbl [64];

   always #5 clk = ~clk;

   label_merge_ctrl #(.LABEL_WIDTH(6), .NUM_LABELS(64), .STARVE_LIMIT(4)) dut (
      .clk(clk), .rst(rst), .frame_start(frame_start), .frame_end(frame_end),
      .mrg_valid(mrg_valid), .mrg_ready(mrg_ready), .mrg_a(mrg_a), .mrg_b(mrg_b),
      .rsv_valid(rsv_valid), .rsv_ready(rsv_ready), .rsv_label(rsv_label),
      .rsp_valid(rsp_valid), .rsp_label(rsp_label),
      .tbl_merge_valid(tbl_merge_valid), .tbl_merge_a(tbl_merge_a), .tbl_merge_b(tbl_merge_b),
      .tbl_resolve_valid(tbl_resolve_valid), .tbl_resolve_label(tbl_resolve_label),
      .tbl_resolved_label(tbl_resolved_label),
      .busy(busy), .flatten_done(flatten_done), .seq_err(seq_err)
   );

   // Table model: parent pointers, combinational root lookup
   always @(posedge clk) begin
      if (tbl_merge_valid) tbl[tbl_merge_b] <= tbl_merge_a;
   end

   always_comb begin
      logic [5:0] r;
      r = tbl_resolve_label;
      for (int k = 0; k < 64; k++) r = tbl[r];
      tbl_resolved_label = r;
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      mrg_valid = 1'b1; mrg_a = 6'd1; mrg_b = 6'd2;
      tick; tick;
      #1;
      checks++;
      if (busy !== 1'b0 || mrg_ready !== 1'b0 || rsp_valid !== 1'b0 || seq_err !== 1'b0 ||
          tbl_merge_valid !== 1'b0 || flatten_done !== 1'b0) begin
         errors++;
         $display("FAIL reset_outputs: busy=%b mrg_ready=%b rsp_valid=%b seq_err=%b tmv=%b fd=%b, required all 0",
                  busy, mrg_ready, rsp_valid, seq_err, tbl_merge_valid, flatten_done);
      end
      rst = 1'b0;
      tick;
      checks++;
      if (mrg_ready !== 1'b0) begin
         errors++;
         $display("FAIL idle_mrg_ready: got %b required 0", mrg_ready);
      end
      mrg_valid = 1'b0;
      frame_end = 1'b1;
      tick;
      frame_end = 1'b0;
      checks++;
      if (seq_err !== 1'b1 || busy !== 1'b0) begin
         errors++;
         $display("FAIL idle_frame_end: seq_err=%b busy=%b required 1/0", seq_err, busy);
      end
      rst = 1'b1;
      #1;
      checks++;
      if (seq_err !== 1'b0) begin
         errors++;
         $display("FAIL seq_err_rst: got %b required 0", seq_err);
      end
      tick;
      rst = 1'b0;
      tick;
   endtask

   task automatic run_clear;
      int n;
      frame_start = 1'b1;
      tick;
      frame_start = 1'b0;
      n = 0;
      while (busy === 1'b1 && n < 200) begin
         checks++;
         if (tbl_merge_valid !== 1'b1 || tbl_merge_a !== 6'(n) || tbl_merge_b !== 6'(n)) begin
            errors++;
            $display("FAIL clear_entry: v=%b a=%0d b=%0d required 1/%0d/%0d",
                     tbl_merge_valid, tbl_merge_a, tbl_merge_b, n, n);
         end
         n++;
         tick;
      end
      checks++;
      if (n != 64) begin
         errors++;
         $display("FAIL clear_length: got %0d busy cycles required 64", n);
      end
   endtask

   task automatic test_merge_resolve;
      mrg_valid = 1'b1; mrg_a = 6'd9; mrg_b = 6'd3;
      #1;
      checks++;
      if (mrg_ready !== 1'b1 || tbl_merge_valid !== 1'b1 || tbl_merge_a !== 6'd3 || tbl_merge_b !== 6'd9) begin
         errors++;
         $display("FAIL merge_9_3: ready=%b v=%b a=%0d b=%0d required 1/1/3/9",
                  mrg_ready, tbl_merge_valid, tbl_merge_a, tbl_merge_b);
      end
      tick;
      mrg_valid = 1'b0;
      rsv_valid = 1'b1; rsv_label = 6'd9;
      #1;
      checks++;
      if (rsv_ready !== 1'b1 || tbl_resolve_valid !== 1'b1 || tbl_resolve_label !== 6'd9) begin
         errors++;
         $display("FAIL resolve_grant: ready=%b v=%b label=%0d required 1/1/9",
                  rsv_ready, tbl_resolve_valid, tbl_resolve_label);
      end
      tick;
      rsv_valid = 1'b0;
      checks++;
      if (rsp_valid !== 1'b1 || rsp_label !== 6'd3) begin
         errors++;
         $display("FAIL resolve_rsp: valid=%b label=%0d required 1/3", rsp_valid, rsp_label);
      end
      tick;
      checks++;
      if (rsp_valid !== 1'b0) begin
         errors++;
         $display("FAIL rsp_single: got %b required 0", rsp_valid);
      end
   endtask

   task automatic test_starvation;
      logic exp_rsv;
      mrg_valid = 1'b1; mrg_a = 6'd30; mrg_b = 6'd31;
      rsv_valid = 1'b1; rsv_label = 6'd1;
      for (int i = 0; i < 10; i++) begin
         exp_rsv = (i == 4 || i == 9);
         #1;
         checks++;
         if (rsv_ready !== exp_rsv || mrg_ready !== !exp_rsv) begin
            errors++;
            $display("FAIL starve_cycle%0d: rsv_ready=%b mrg_ready=%b required %b/%b",
                     i, rsv_ready, mrg_ready, exp_rsv, !exp_rsv);
         end
         checks++;
         if (rsp_valid !== (i == 5) || (i == 5 && rsp_label !== 6'd1)) begin
            errors++;
            $display("FAIL starve_rsp%0d: valid=%b label=%0d required %b/1", i, rsp_valid, rsp_label, (i == 5));
         end
         tick;
      end
      mrg_valid = 1'b0;
      rsv_valid = 1'b0;
      tick;
   endtask

   task automatic do_merge(input logic [5:0] a, input logic [5:0] b);
      mrg_valid = 1'b1; mrg_a = a; mrg_b = b;
      tick;
      mrg_valid = 1'b0;
   endtask

   task automatic run_flatten(input bit inject_start, output int n);
      frame_end = 1'b1;
      tick;
      frame_end = 1'b0;
      checks++;
      if (busy !== 1'b1 || flatten_done !== 1'b0 || mrg_ready !== 1'b0) begin
         errors++;
         $display("FAIL flatten_entry: busy=%b fd=%b mrg_ready=%b required 1/0/0", busy, flatten_done, mrg_ready);
      end
      n = 0;
      while (busy === 1'b1 && n < 200) begin
         frame_start = inject_start && (n == 10);
         n++;
         tick;
      end
      frame_start = 1'b0;
   endtask

   task automatic test_flatten;
      int n;
      do_merge(6'd2, 6'd5);
      do_merge(6'd5, 6'd7);
      do_merge(6'd7, 6'd12);
      frame_end = 1'b1;
      tick;
      frame_end = 1'b0;
      n = 0;
      while (busy === 1'b1 && n < 200) begin
         if (n == 5 || n == 7 || n == 12 || n == 9) begin
            checks++;
            if (tbl_merge_b !== 6'(n) || tbl_merge_a !== ((n == 9) ? 6'd3 : 6'd2) || tbl_resolve_label !== 6'(n)) begin
               errors++;
               $display("FAIL flatten_entry%0d: a=%0d b=%0d rl=%0d required %0d/%0d/%0d",
                        n, tbl_merge_a, tbl_merge_b, tbl_resolve_label, (n == 9) ? 3 : 2, n, n);
            end
         end
         n++;
         tick;
      end
      checks++;
      if (n != 64 || flatten_done !== 1'b1) begin
         errors++;
         $display("FAIL flatten_done: cycles=%0d done=%b required 64/1", n, flatten_done);
      end
      mrg_valid = 1'b1; mrg_a = 6'd1; mrg_b = 6'd2;
      rsv_valid = 1'b1; rsv_label = 6'd12;
      #1;
      checks++;
      if (rsv_ready !== 1'b1 || mrg_ready !== 1'b0 || tbl_merge_valid !== 1'b0) begin
         errors++;
         $display("FAIL frozen_arb: rsv_ready=%b mrg_ready=%b tmv=%b required 1/0/0",
                  rsv_ready, mrg_ready, tbl_merge_valid);
      end
      tick;
      mrg_valid = 1'b0;
      rsv_valid = 1'b0;
      checks++;
      if (flatten_done !== 1'b0 || rsp_valid !== 1'b1 || rsp_label !== 6'd2 || seq_err !== 1'b0) begin
         errors++;
         $display("FAIL frozen_resolve12: fd=%b valid=%b label=%0d seq_err=%b required 0/1/2/0",
                  flatten_done, rsp_valid, rsp_label, seq_err);
      end
   endtask

   task automatic test_self_merge;
      mrg_valid = 1'b1; mrg_a = 6'd4; mrg_b = 6'd4;
      #1;
      checks++;
      if (mrg_ready !== 1'b1 || tbl_merge_valid !== 1'b0) begin
         errors++;
         $display("FAIL self_merge: ready=%b tmv=%b required 1/0", mrg_ready, tbl_merge_valid);
      end
      tick;
      mrg_valid = 1'b0;
      rsv_valid = 1'b1; rsv_label = 6'd4;
      tick;
      rsv_valid = 1'b0;
      checks++;
      if (rsp_valid !== 1'b1 || rsp_label !== 6'd4) begin
         errors++;
         $display("FAIL self_merge_resolve: valid=%b label=%0d required 1/4", rsp_valid, rsp_label);
      end
   endtask

   task automatic test_seq_err_and_rst;
      int n;
      run_flatten(1'b1, n);
      checks++;
      if (n != 64 || flatten_done !== 1'b1 || seq_err !== 1'b1) begin
         errors++;
         $display("FAIL start_in_flatten: cycles=%0d fd=%b seq_err=%b required 64/1/1", n, flatten_done, seq_err);
      end
      frame_start = 1'b1;
      tick;
      frame_start = 1'b0;
      repeat (5) tick;
      checks++;
      if (busy !== 1'b1 || tbl_merge_a !== 6'd5) begin
         errors++;
         $display("FAIL clear_progress: busy=%b a=%0d required 1/5", busy, tbl_merge_a);
      end
      #2;
      rst = 1'b1;
      #1;
      checks++;
      if (busy !== 1'b0 || seq_err !== 1'b0 || tbl_merge_valid !== 1'b0 || rsp_valid !== 1'b0 ||
          flatten_done !== 1'b0 || tbl_merge_a !== 6'd0) begin
         errors++;
         $display("FAIL rst_mid_clear: busy=%b seq_err=%b tmv=%b a=%0d required 0/0/0/0",
                  busy, seq_err, tbl_merge_valid, tbl_merge_a);
      end
      tick;
      rst = 1'b0;
      mrg_valid = 1'b1; mrg_a = 6'd1; mrg_b = 6'd2;
      tick;
      checks++;
      if (busy !== 1'b0 || mrg_ready !== 1'b0) begin
         errors++;
         $display("FAIL idle_after_rst: busy=%b mrg_ready=%b required 0/0", busy, mrg_ready);
      end
      mrg_valid = 1'b0;
   endtask

   initial begin
      test_reset;
      run_clear;
      test_merge_resolve;
      test_starvation;
      test_flatten;
      run_clear;
      test_self_merge;
      test_seq_err_and_rst;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
